// File: rtl/elevator_scheduler.sv
// Single-car elevator controller: latches floor calls and serves them with
// LOOK scheduling, stepping one floor per travel interval and timing the door.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   req         per-floor call buttons
//   floor       current car floor index
//   moving_up   car travelling up
//   moving_down car travelling down
//   door_open   door dwell in progress
//   pending     registered outstanding calls
module elevator_scheduler #(
  parameter int NFLOORS     = 6,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] req,
  output logic [3:0]         floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic [NFLOORS-1:0] pending
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MLAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DOOR_CYCLES - 1);
  localparam logic [3:0]    FTOP  = 4'(NFLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DOOR
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         floor_q, floor_d;
  logic [NFLOORS-1:0] pend_q, pend_d;
  logic               last_up_q, last_up_d;
  logic [MW-1:0]      move_cnt_q, move_cnt_d;
  logic [DW-1:0]      door_cnt_q, door_cnt_d;

  logic [NFLOORS-1:0] f_oh, nf_oh;
  logic [3:0]         nf;
  logic               here, above, below;
  logic               nf_here, nf_above, nf_below;
  logic               req_here;

  function automatic logic any_above(
    input logic [NFLOORS-1:0] p,
    input logic [3:0]         f
  );
    any_above = 1'b0;
    for (int i = 0; i < NFLOORS; i++)
      if (p[i] && (i > int'(f))) any_above = 1'b1;
  endfunction

  function automatic logic any_below(
    input logic [NFLOORS-1:0] p,
    input logic [3:0]         f
  );
    any_below = 1'b0;
    for (int i = 0; i < NFLOORS; i++)
      if (p[i] && (i < int'(f))) any_below = 1'b1;
  endfunction

  // Floor one step along the current travel direction, clamped at the ends.
  always_comb begin
    nf = floor_q;
    if (state_q == S_UP && floor_q != FTOP)
      nf = floor_q + 4'd1;
    else if (state_q == S_DOWN && floor_q != 4'd0)
      nf = floor_q - 4'd1;
  end

  assign f_oh     = NFLOORS'(1) << floor_q;
  assign nf_oh    = NFLOORS'(1) << nf;
  assign here     = |(pend_q & f_oh);
  assign req_here = |(req & f_oh);
  assign above    = any_above(pend_q, floor_q);
  assign below    = any_below(pend_q, floor_q);
  assign nf_here  = |(pend_q & nf_oh);
  assign nf_above = any_above(pend_q, nf);
  assign nf_below = any_below(pend_q, nf);

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_up_d  = last_up_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    pend_d     = pend_q | req;
    unique case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d    = S_DOOR;
          door_cnt_d = '0;
        end else if (above) begin
          state_d    = S_UP;
          last_up_d  = 1'b1;
          move_cnt_d = '0;
        end else if (below) begin
          state_d    = S_DOWN;
          last_up_d  = 1'b0;
          move_cnt_d = '0;
        end
      end
      S_UP, S_DOWN: begin
        if (move_cnt_q == MLAST) begin
          move_cnt_d = '0;
          floor_d    = nf;
          if (nf_here) begin
            state_d    = S_DOOR;
            door_cnt_d = '0;
          end else if (state_q == S_UP && nf_above) begin
            state_d = S_UP;
          end else if (state_q == S_DOWN && nf_below) begin
            state_d = S_DOWN;
          end else if (state_q == S_UP && nf_below) begin
            state_d   = S_DOWN;
            last_up_d = 1'b0;
          end else if (state_q == S_DOWN && nf_above) begin
            state_d   = S_UP;
            last_up_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          move_cnt_d = move_cnt_q + MW'(1);
        end
      end
      S_DOOR: begin
        // A press at the open floor is absorbed and holds the door.
        pend_d = (pend_q | req) & ~f_oh;
        if (req_here) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DLAST) begin
          move_cnt_d = '0;
          if (last_up_q) begin
            if (above) state_d = S_UP;
            else if (below) begin
              state_d   = S_DOWN;
              last_up_d = 1'b0;
            end else state_d = S_IDLE;
          end else begin
            if (below) state_d = S_DOWN;
            else if (above) begin
              state_d   = S_UP;
              last_up_d = 1'b1;
            end else state_d = S_IDLE;
          end
        end else begin
          door_cnt_d = door_cnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      floor_q    <= '0;
      pend_q     <= '0;
      last_up_q  <= 1'b1;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      pend_q     <= pend_d;
      last_up_q  <= last_up_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  assign floor       = floor_q;
  assign pending     = pend_q;
  assign moving_up   = (state_q == S_UP);
  assign moving_down = (state_q == S_DOWN);
  assign door_open   = (state_q == S_DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_elevator_scheduler;

  localparam int NF = 6;
  localparam int MC = 4;
  localparam int DC = 8;

  logic          clk;
  logic          reset;
  logic [NF-1:0] req;
  logic [3:0]    floor;
  logic          moving_up;
  logic          moving_down;
  logic          door_open;
  logic [NF-1:0] pending;

  int errors = 0;
  int checks = 0;

  elevator_scheduler #(
    .NFLOORS    (NF),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 up, 2 down, 3 door; left counts the
  // cycles remaining in the current travel or dwell interval.
  int            m_f;
  int            m_mode;
  int            m_left;
  bit            m_lastup;
  bit [NF-1:0]   m_pend;

  function automatic bit m_above(input bit [NF-1:0] p, input int f);
    for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_below(input bit [NF-1:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit [NF-1:0] r, input bit rs);
    bit [NF-1:0] p;
    bit [NF-1:0] np;
    if (rs) begin
      m_f = 0; m_mode = 0; m_left = 0; m_lastup = 1'b1; m_pend = '0;
      return;
    end
    p  = m_pend;
    np = p | r;
    if (m_mode == 3) np[m_f] = 1'b0;
    case (m_mode)
      0: begin
        if (p[m_f]) begin
          m_mode = 3; m_left = DC;
        end else if (m_above(p, m_f)) begin
          m_mode = 1; m_left = MC; m_lastup = 1'b1;
        end else if (m_below(p, m_f)) begin
          m_mode = 2; m_left = MC; m_lastup = 1'b0;
        end
      end
      1, 2: begin
        if (m_left > 1) m_left--;
        else begin
          m_f += (m_mode == 1) ? 1 : -1;
          m_left = MC;
          if (p[m_f]) begin
            m_mode = 3; m_left = DC;
          end else if (m_mode == 1 && m_above(p, m_f)) begin
          end else if (m_mode == 2 && m_below(p, m_f)) begin
          end else if (m_mode == 1 && m_below(p, m_f)) begin
            m_mode = 2; m_lastup = 1'b0;
          end else if (m_mode == 2 && m_above(p, m_f)) begin
            m_mode = 1; m_lastup = 1'b1;
          end else m_mode = 0;
        end
      end
      default: begin
        if (r[m_f]) m_left = DC;
        else if (m_left > 1) m_left--;
        else begin
          m_left = MC;
          if (m_lastup) begin
            if (m_above(p, m_f)) m_mode = 1;
            else if (m_below(p, m_f)) begin
              m_mode = 2; m_lastup = 1'b0;
            end else m_mode = 0;
          end else begin
            if (m_below(p, m_f)) m_mode = 2;
            else if (m_above(p, m_f)) begin
              m_mode = 1; m_lastup = 1'b1;
            end else m_mode = 0;
          end
        end
      end
    endcase
    m_pend = np;
  endtask

  // One clock: apply inputs for the edge, advance the model, sample after.
  task automatic tick(input logic [NF-1:0] r, input logic rs);
    req   = r;
    reset = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    req   = '0;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!moving_up && !moving_down && !door_open && pending == '0) begin
        ok = 1'b1;
        return;
      end
      tick('0, 1'b0);
    end
  endtask

  task automatic test_reset;
    tick('0, 1'b1);
    checks++;
    if ({floor, moving_up, moving_down, door_open, pending} !== '0) begin
      errors++;
      $display("FAIL reset_state: got floor=%0d mu=%b md=%b do=%b pend=%b want all 0",
               floor, moving_up, moving_down, door_open, pending);
    end
  endtask

  task automatic test_basic_trip;
    tick(6'b001000, 1'b0);
    checks++;
    if (pending !== 6'b001000 || moving_up !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1: pend=%b mu=%b want 001000 0", pending, moving_up);
    end
    tick('0, 1'b0);
    checks++;
    if (moving_up !== 1'b1 || floor !== 4'd0) begin
      errors++;
      $display("FAIL basic_c2: mu=%b floor=%0d want 1 0", moving_up, floor);
    end
    repeat (4) tick('0, 1'b0);
    checks++;
    if (floor !== 4'd1) begin
      errors++;
      $display("FAIL basic_c6: floor=%0d want 1", floor);
    end
    repeat (4) tick('0, 1'b0);
    checks++;
    if (floor !== 4'd2) begin
      errors++;
      $display("FAIL basic_c10: floor=%0d want 2", floor);
    end
    repeat (4) tick('0, 1'b0);
    checks++;
    if (floor !== 4'd3 || door_open !== 1'b1 || moving_up !== 1'b0) begin
      errors++;
      $display("FAIL basic_c14: floor=%0d do=%b mu=%b want 3 1 0",
               floor, door_open, moving_up);
    end
    repeat (7) tick('0, 1'b0);
    checks++;
    if (door_open !== 1'b1) begin
      errors++;
      $display("FAIL basic_c21: do=%b want 1", door_open);
    end
    tick('0, 1'b0);
    checks++;
    if ({moving_up, moving_down, door_open} !== 3'b000 ||
        pending !== '0 || floor !== 4'd3) begin
      errors++;
      $display("FAIL basic_c22: mu=%b md=%b do=%b pend=%b floor=%0d want idle at 3",
               moving_up, moving_down, door_open, pending, floor);
    end
  endtask

  task automatic test_door_here;
    bit ok;
    int open;
    int moved;
    tick(6'b000100, 1'b0);
    wait_idle(60, ok);
    checks++;
    if (!ok || floor !== 4'd2) begin
      errors++;
      $display("FAIL here_setup: ok=%b floor=%0d want 1 2", ok, floor);
    end
    tick(6'b000100, 1'b0);
    checks++;
    if (pending !== 6'b000100 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL here_latch: pend=%b do=%b want 000100 0", pending, door_open);
    end
    open = 0;
    moved = 0;
    for (int i = 0; i < 20; i++) begin
      tick('0, 1'b0);
      if (door_open) open++;
      if (floor !== 4'd2 || moving_up || moving_down) moved++;
    end
    checks++;
    if (open != DC || moved != 0 || pending !== '0) begin
      errors++;
      $display("FAIL here_dwell: open=%0d moved=%0d pend=%b want %0d 0 0",
               open, moved, pending, DC);
    end
  endtask

  task automatic test_look_reversal;
    int seq[$];
    int exp_seq[9] = '{2, 3, 4, 5, 4, 3, 2, 1, 0};
    bit ok;
    tick(6'b100001, 1'b0);
    tick('0, 1'b0);
    checks++;
    if (moving_up !== 1'b1 || moving_down !== 1'b0) begin
      errors++;
      $display("FAIL look_first: mu=%b md=%b want 1 0", moving_up, moving_down);
    end
    seq.push_back(int'(floor));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick('0, 1'b0);
      if (int'(floor) != seq[$]) seq.push_back(int'(floor));
      if (!moving_up && !moving_down && !door_open && pending == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (seq.size() == 9)
      for (int i = 0; i < 9; i++) if (seq[i] != exp_seq[i]) ok = 1'b0;
    checks++;
    if (!ok || seq.size() != 9) begin
      errors++;
      $display("FAIL look_seq: got %p want %p", seq, exp_seq);
    end
  endtask

  task automatic test_door_extend;
    int open;
    bit leak;
    bit ok;
    tick(6'b010000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (door_open) begin
        ok = 1'b1;
        break;
      end
      tick('0, 1'b0);
    end
    checks++;
    if (!ok || floor !== 4'd4) begin
      errors++;
      $display("FAIL ext_arrive: door=%b floor=%0d want 1 4", ok, floor);
    end
    open = 1;
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick('0, 1'b0);
      if (door_open) open++;
    end
    tick(6'b010000, 1'b0);
    if (door_open) open++;
    if (pending[4]) leak = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick('0, 1'b0);
      if (pending[4]) leak = 1'b1;
      if (door_open) open++;
      else break;
    end
    checks++;
    if (open != 15 || leak) begin
      errors++;
      $display("FAIL ext_dwell: open=%0d pend4_seen=%b want 15 0", open, leak);
    end
  endtask

  task automatic test_intermediate_stop;
    int stops[$];
    bit ok;
    bit prev;
    tick(6'b000010, 1'b0);
    wait_idle(80, ok);
    tick(6'b010000, 1'b0);
    tick('0, 1'b0);
    checks++;
    if (!ok || floor !== 4'd1 || moving_up !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: ok=%b floor=%0d mu=%b want 1 1 1", ok, floor, moving_up);
    end
    tick(6'b001001, 1'b0);
    prev = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (door_open && !prev) stops.push_back(int'(floor));
      prev = door_open;
      if (!moving_up && !moving_down && !door_open && pending == '0) begin
        ok = 1'b1;
        break;
      end
      tick('0, 1'b0);
    end
    checks++;
    if (!ok || stops.size() != 3 || stops[0] != 3 || stops[1] != 4 || stops[2] != 0) begin
      errors++;
      $display("FAIL mid_stops: got %p want '{3, 4, 0}", stops);
    end
  endtask

  task automatic test_reset_mid_move;
    bit ok;
    tick(6'b001000, 1'b0);
    wait_idle(80, ok);
    tick(6'b000001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (moving_down) break;
      tick('0, 1'b0);
    end
    repeat (2) tick('0, 1'b0);
    checks++;
    if (!ok || floor !== 4'd3 || moving_down !== 1'b1) begin
      errors++;
      $display("FAIL rmid_setup: ok=%b floor=%0d md=%b want 1 3 1", ok, floor, moving_down);
    end
    tick(6'b000100, 1'b1);
    checks++;
    if ({floor, moving_up, moving_down, door_open, pending} !== '0) begin
      errors++;
      $display("FAIL rmid_clear: floor=%0d mu=%b md=%b do=%b pend=%b want all 0",
               floor, moving_up, moving_down, door_open, pending);
    end
    tick(6'b000010, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (door_open) begin
        ok = 1'b1;
        break;
      end
      tick('0, 1'b0);
    end
    checks++;
    if (!ok || floor !== 4'd1) begin
      errors++;
      $display("FAIL rmid_serve: door=%b floor=%0d want 1 1", ok, floor);
    end
  endtask

  task automatic test_random;
    logic [NF-1:0] r;
    logic          rs;
    tick('0, 1'b1);
    for (int c = 0; c < 4000; c++) begin
      r  = '0;
      rs = 1'b0;
      if ($urandom_range(4) == 0) r[$urandom_range(NF - 1)] = 1'b1;
      if ($urandom_range(22) == 0) r = r | NF'($urandom);
      if ($urandom_range(699) == 0) rs = 1'b1;
      tick(r, rs);
      checks++;
      if (floor !== 4'(m_f) || moving_up !== (m_mode == 1) ||
          moving_down !== (m_mode == 2) || door_open !== (m_mode == 3) ||
          pending !== m_pend) begin
        errors++;
        $display("FAIL rand_cycle%0d: floor=%0d mu=%b md=%b do=%b pend=%b want %0d %b %b %b %b",
                 c, floor, moving_up, moving_down, door_open, pending,
                 m_f, m_mode == 1, m_mode == 2, m_mode == 3, m_pend);
        if (errors > 20) break;
      end
    end
  endtask

  initial begin
    req   = '0;
    reset = 1'b1;
    test_reset;
    test_basic_trip;
    test_door_here;
    test_look_reversal;
    test_door_extend;
    test_intermediate_stop;
    test_reset_mid_move;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
